// File: rtl/arm_pipe_pkg.sv
// Shared pipeline constants and types for the hazard, forwarding and
// register-write tracking logic.
package arm_pipe_pkg;

    localparam int REG_W    = 4;
    localparam int NUM_REGS = 1 << REG_W;
    localparam int CNT_W    = 2;

    typedef logic [REG_W-1:0] reg_idx_t;

    localparam reg_idx_t PC_REG = 4'd15;

endpackage

// File: rtl/sb_counter.sv
// Saturating-free up/down counter for one register's outstanding writes;
// the owner gates inc when full, and dec at zero is absorbed here.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_o,
    output logic full_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q, count_d;

    assign zero_o = (count_q == '0);
    assign full_o = (count_q == '1);

    // Simultaneous inc and dec cancel; a dec at zero leaves the count at zero.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else begin
            unique case ({inc_i, dec_i})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = zero_o ? count_q : (count_q - ONE);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/reg_write_scoreboard.sv
// Per-register outstanding-write scoreboard: decode bumps a counter on issue,
// writeback drops it, and busy/hazard come straight from the registered counts.
module reg_write_scoreboard #(
    parameter int REG_W    = arm_pipe_pkg::REG_W,
    parameter int NUM_REGS = arm_pipe_pkg::NUM_REGS,
    parameter int CNT_W    = arm_pipe_pkg::CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   issue_valid,
    input  logic                   issue_wb_en,
    input  logic [REG_W-1:0]       issue_dest,
    output logic                   issue_ready,
    input  logic                   wb_valid,
    input  logic [REG_W-1:0]       wb_dest,
    input  logic [REG_W-1:0]       src1,
    input  logic [REG_W-1:0]       src2,
    input  logic                   two_src,
    output logic                   hazard,
    output logic [NUM_REGS-1:0]    busy_vec,
    output logic [REG_W+CNT_W-1:0] outstanding,
    output logic                   underflow_err
);

    localparam int OUT_W = REG_W + CNT_W;
    localparam logic [OUT_W-1:0] OUT_ONE = {{(OUT_W-1){1'b0}}, 1'b1};

    logic [NUM_REGS-1:0] inc, dec, zero, full;
    logic                accept, same_reg, retire_ok;
    logic [OUT_W-1:0]    outstanding_q, outstanding_d;
    logic                underflow_q, underflow_d;

    assign issue_ready = ~full[issue_dest];
    assign accept      = issue_valid & issue_wb_en & issue_ready;
    assign same_reg    = accept & wb_valid & (issue_dest == wb_dest);
    // A retire counts only if it removes a real write; an issue to the same
    // register in the same cycle supplies that write even from a zero count.
    assign retire_ok   = wb_valid & (~zero[wb_dest] | same_reg);

    always_comb begin
        inc = '0;
        dec = '0;
        if (accept)   inc[issue_dest] = 1'b1;
        if (wb_valid) dec[wb_dest]    = 1'b1;
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr_i  (flush),
            .inc_i  (inc[r]),
            .dec_i  (dec[r]),
            .zero_o (zero[r]),
            .full_o (full[r])
        );
    end

    always_comb begin
        outstanding_d = outstanding_q;
        underflow_d   = underflow_q;
        if (flush) begin
            outstanding_d = '0;
            underflow_d   = 1'b0;
        end else begin
            unique case ({accept, retire_ok})
                2'b10:   outstanding_d = outstanding_q + OUT_ONE;
                2'b01:   outstanding_d = outstanding_q - OUT_ONE;
                default: outstanding_d = outstanding_q;
            endcase
            underflow_d = underflow_q | (wb_valid & zero[wb_dest] & ~same_reg);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            underflow_q   <= underflow_d;
        end
    end

    assign busy_vec      = ~zero;
    assign hazard        = busy_vec[src1] | (two_src & busy_vec[src2]);
    assign outstanding   = outstanding_q;
    assign underflow_err = underflow_q;

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Bench for reg_write_scoreboard: directed vector table, async reset corner,
// and a randomized phase checked against a per-register count model.
module tb_reg_write_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_wb_en = 1'b0;
    logic [3:0]  issue_dest = '0;
    logic        issue_ready;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_dest = '0;
    logic [3:0]  src1 = '0;
    logic [3:0]  src2 = '0;
    logic        two_src = 1'b0;
    logic        hazard;
    logic [15:0] busy_vec;
    logic [5:0]  outstanding;
    logic        underflow_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        fl;
        logic        iv;
        logic        iwb;
        logic [3:0]  idest;
        logic        wv;
        logic [3:0]  wdest;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic        two;
        logic        ready;
        logic        haz;
        logic [15:0] busy;
        logic [5:0]  outs;
        logic        uerr;
    } vec_t;

    typedef struct {
        logic [15:0] busy;
        logic [5:0]  outs;
        logic        uerr;
    } post_t;

    vec_t  tbl[$];
    post_t exp_q[$];
    int    cnt[16];

    reg_write_scoreboard dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_wb_en   (issue_wb_en),
        .issue_dest    (issue_dest),
        .issue_ready   (issue_ready),
        .wb_valid      (wb_valid),
        .wb_dest       (wb_dest),
        .src1          (src1),
        .src2          (src2),
        .two_src       (two_src),
        .hazard        (hazard),
        .busy_vec      (busy_vec),
        .outstanding   (outstanding),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic fl, input logic iv, input logic iwb, input int idest,
                       input logic wv, input int wdest, input int s1, input int s2,
                       input logic two, input logic rdy, input logic hz,
                       input int busy, input int outs, input logic ue);
        vec_t v;
        v.fl = fl;  v.iv = iv;  v.iwb = iwb;  v.idest = 4'(idest);
        v.wv = wv;  v.wdest = 4'(wdest);  v.s1 = 4'(s1);  v.s2 = 4'(s2);
        v.two = two;  v.ready = rdy;  v.haz = hz;
        v.busy = 16'(busy);  v.outs = 6'(outs);  v.uerr = ue;
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        flush = v.fl;  issue_valid = v.iv;  issue_wb_en = v.iwb;  issue_dest = v.idest;
        wb_valid = v.wv;  wb_dest = v.wdest;  src1 = v.s1;  src2 = v.s2;  two_src = v.two;
    endtask

    task automatic pop_check(input string tag);
        post_t p;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.queue: actual empty required one entry", tag);
        end else begin
            p = exp_q.pop_front();
            check({tag, ".busy_vec"}, 32'(busy_vec), 32'(p.busy));
            check({tag, ".outstanding"}, 32'(outstanding), 32'(p.outs));
            check({tag, ".underflow_err"}, 32'(underflow_err), 32'(p.uerr));
        end
    endtask

    // Inputs are driven just after a rising edge; combinational outputs are
    // checked before the next edge, registered outputs just after it.
    task automatic step(input string tag, input vec_t v);
        post_t p;
        drive(v);
        #1;
        check({tag, ".issue_ready"}, 32'(issue_ready), 32'(v.ready));
        check({tag, ".hazard"}, 32'(hazard), 32'(v.haz));
        p.busy = v.busy;  p.outs = v.outs;  p.uerr = v.uerr;
        exp_q.push_back(p);
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        // fl iv iwb id  wv wd  s1 s2 two  rdy hz  busy     out ue
        add(0, 1, 1, 5,  0, 0,  5, 0, 0,   1, 0, 16'h0020, 1, 0);  // issue R5
        add(0, 0, 0, 0,  0, 0,  5, 0, 0,   1, 1, 16'h0020, 1, 0);  // hazard src1
        add(0, 0, 0, 0,  1, 5,  5, 0, 0,   1, 1, 16'h0000, 0, 0);  // retire, still hazard
        add(0, 0, 0, 0,  0, 0,  5, 0, 0,   1, 0, 16'h0000, 0, 0);  // hazard dropped
        add(0, 1, 1, 5,  0, 0,  0, 0, 0,   1, 0, 16'h0020, 1, 0);
        add(0, 0, 0, 0,  0, 0,  0, 5, 0,   1, 0, 16'h0020, 1, 0);  // src2 ignored
        add(0, 0, 0, 0,  0, 0,  0, 5, 1,   1, 1, 16'h0020, 1, 0);  // src2 real
        add(0, 0, 0, 0,  1, 5,  0, 0, 0,   1, 0, 16'h0000, 0, 0);
        add(0, 1, 1, 2,  0, 0,  0, 0, 0,   1, 0, 16'h0004, 1, 0);  // saturate R2
        add(0, 1, 1, 2,  0, 0,  0, 0, 0,   1, 0, 16'h0004, 2, 0);
        add(0, 1, 1, 2,  0, 0,  0, 0, 0,   1, 0, 16'h0004, 3, 0);
        add(0, 1, 1, 2,  0, 0,  0, 0, 0,   0, 0, 16'h0004, 3, 0);  // refused
        add(0, 1, 1, 4,  0, 0,  0, 0, 0,   1, 0, 16'h0014, 4, 0);  // other reg ok
        add(0, 1, 1, 2,  1, 2,  0, 0, 0,   0, 0, 16'h0014, 3, 0);  // full + retire
        add(0, 1, 1, 2,  0, 0,  0, 0, 0,   1, 0, 16'h0014, 4, 0);
        add(0, 0, 0, 2,  1, 2,  0, 0, 0,   0, 0, 16'h0014, 3, 0);
        add(0, 0, 0, 2,  0, 0,  0, 0, 0,   1, 0, 16'h0014, 3, 0);  // ready again
        add(0, 0, 0, 0,  1, 2,  0, 0, 0,   1, 0, 16'h0014, 2, 0);
        add(0, 0, 0, 0,  1, 2,  0, 0, 0,   1, 0, 16'h0010, 1, 0);
        add(0, 0, 0, 0,  1, 4,  0, 0, 0,   1, 0, 16'h0000, 0, 0);
        add(0, 1, 1, 7,  0, 0,  7, 0, 0,   1, 0, 16'h0080, 1, 0);  // simultaneous R7
        add(0, 1, 1, 7,  1, 7,  7, 0, 0,   1, 1, 16'h0080, 1, 0);
        add(0, 0, 0, 0,  0, 0,  7, 0, 0,   1, 1, 16'h0080, 1, 0);
        add(0, 0, 0, 0,  1, 7,  7, 0, 0,   1, 1, 16'h0000, 0, 0);
        add(0, 1, 0, 3,  0, 0,  0, 0, 0,   1, 0, 16'h0000, 0, 0);  // no wb_en
        add(0, 1, 1, 1,  0, 0,  0, 0, 0,   1, 0, 16'h0002, 1, 0);
        add(0, 1, 1, 3,  1, 1,  0, 0, 0,   1, 0, 16'h0008, 1, 0);  // different regs
        add(0, 0, 0, 0,  1, 3,  0, 0, 0,   1, 0, 16'h0000, 0, 0);
        add(0, 0, 0, 0,  1, 9,  0, 0, 0,   1, 0, 16'h0000, 0, 1);  // underflow
        add(0, 1, 1, 1,  0, 0,  0, 0, 0,   1, 0, 16'h0002, 1, 1);  // sticky
        add(0, 1, 1, 1,  0, 0,  0, 0, 0,   1, 0, 16'h0002, 2, 1);
        add(0, 1, 1, 6,  0, 0,  0, 0, 0,   1, 0, 16'h0042, 3, 1);
        add(1, 1, 1, 1,  1, 6,  0, 0, 0,   1, 0, 16'h0000, 0, 0);  // flush wins
        add(0, 0, 0, 0,  0, 0,  1, 6, 1,   1, 0, 16'h0000, 0, 0);

        rst_n = 1'b0;
        #2;
        check("reset.busy_vec", 32'(busy_vec), 32'h0);
        check("reset.outstanding", 32'(outstanding), 32'h0);
        check("reset.underflow_err", 32'(underflow_err), 32'h0);
        check("reset.issue_ready", 32'(issue_ready), 32'h1);
        check("reset.hazard", 32'(hazard), 32'h0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // Asynchronous reset in the middle of a cycle, no clock edge needed.
        begin
            vec_t v;
            v = '{fl: 1'b0, iv: 1'b1, iwb: 1'b1, idest: 4'd3, wv: 1'b0, wdest: 4'd0,
                  s1: 4'd0, s2: 4'd0, two: 1'b0, ready: 1'b1, haz: 1'b0,
                  busy: 16'h0008, outs: 6'd1, uerr: 1'b0};
            step("rstmid.a", v);
            v.outs = 6'd2;
            step("rstmid.b", v);
            issue_valid = 1'b0;
            rst_n = 1'b0;
            #2;
            check("rstmid.busy_vec", 32'(busy_vec), 32'h0);
            check("rstmid.outstanding", 32'(outstanding), 32'h0);
            check("rstmid.issue_ready", 32'(issue_ready), 32'h1);
            #2;
            rst_n = 1'b1;
            @(posedge clk);
            #1;
        end

        // Randomized traffic against a per-register count model.
        for (int r = 0; r < 16; r++) cnt[r] = 0;
        begin
            logic m_uerr = 1'b0;
            int   m_out  = 0;
            for (int c = 0; c < 300; c++) begin
                vec_t  v;
                post_t p;
                logic  acc;
                v.fl    = ($urandom_range(0, 39) == 0);
                v.iv    = ($urandom_range(0, 3) != 0);
                v.iwb   = ($urandom_range(0, 4) != 0);
                v.idest = 4'($urandom_range(0, 7));
                v.wv    = ($urandom_range(0, 2) == 0);
                v.wdest = 4'($urandom_range(0, 7));
                v.s1    = 4'($urandom_range(0, 15));
                v.s2    = 4'($urandom_range(0, 15));
                v.two   = 1'($urandom_range(0, 1));
                v.ready = (cnt[v.idest] != 3);
                v.haz   = (cnt[v.s1] != 0) || (v.two && cnt[v.s2] != 0);
                acc = v.iv && v.iwb && v.ready;
                if (v.fl) begin
                    for (int r = 0; r < 16; r++) cnt[r] = 0;
                    m_out  = 0;
                    m_uerr = 1'b0;
                end else if (!(acc && v.wv && v.idest == v.wdest)) begin
                    if (acc) begin
                        cnt[v.idest]++;
                        m_out++;
                    end
                    if (v.wv) begin
                        if (cnt[v.wdest] == 0) begin
                            m_uerr = 1'b1;
                        end else begin
                            cnt[v.wdest]--;
                            m_out--;
                        end
                    end
                end
                p.busy = '0;
                for (int r = 0; r < 16; r++) p.busy[r] = (cnt[r] != 0);
                v.busy = p.busy;
                v.outs = 6'(m_out);
                v.uerr = m_uerr;
                step($sformatf("rnd%0d", c), v);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_write_scoreboard.md
Name: reg_write_scoreboard

Overview:
Tracks outstanding register writes issued by the decode stage and retired at writeback. It is the producer of "pending destination" state, the writer side of the hazard check. Decode consults its busy outputs to stall readers. It replaces per-stage dest/wb_en comparison with per-register outstanding-write counters, so any pipeline depth between ID and WB is covered.

Parameters:
REG_W, 4, register index width
NUM_REGS, 16, number of architectural registers (2**REG_W)
CNT_W, 2, per-register outstanding-write counter width (max 2**CNT_W-1 in flight)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all tracking (branch taken / pipeline flush)
issue_valid  in  1  instruction leaving ID this cycle
issue_wb_en  in  1  issuing instruction writes a register
issue_dest  in  REG_W  destination of issuing instruction
issue_ready  out  1  issue accepted; low when issue_dest counter saturated
wb_valid  in  1  writeback stage retiring a register write
wb_dest  in  REG_W  register being written back
src1  in  REG_W  first source of instruction in ID
src2  in  REG_W  second source of instruction in ID
two_src  in  1  src2 is a real operand
hazard  out  1  src1 pending, or (two_src and src2 pending)
busy_vec  out  NUM_REGS  bit i = counter i nonzero
outstanding  out  REG_W+CNT_W  total writes in flight
underflow_err  out  1  sticky: retire seen for register with count 0

Behaviour:
- Reset (rst_n=0, async): all counters 0, outstanding 0, underflow_err 0. Hence busy_vec=0, hazard=0, issue_ready=1.
- Issue accepted when issue_valid & issue_wb_en & issue_ready. issue_valid with issue_wb_en=0 changes no state.
- issue_ready = (count[issue_dest] != max), combinational. When 0, decode must hold the instruction. The counter is not incremented.
- Retire: wb_valid decrements count[wb_dest] on the next rising edge.
- Retire when count[wb_dest]==0: counter stays 0, outstanding unchanged, underflow_err set until reset or flush.
- Same-cycle accepted issue and retire, same register: counter unchanged, outstanding unchanged.
- Same-cycle accepted issue and retire, different registers: one counter +1, the other -1, outstanding unchanged.
- Saturated register with same-cycle retire: issue_ready still 0 (computed from registered count). Retire proceeds, giving count max-1.
- flush=1: on the next edge all counters and outstanding go to 0 and underflow_err clears. Flush overrides issue and retire in that cycle.
- hazard and busy_vec are combinational from registered counters only. A same-cycle retire does not clear hazard and a same-cycle issue does not raise it, so the latency from retire to hazard drop is 1 cycle.
- outstanding = sum of all counters, kept as a registered running total, never recomputed by adder tree.
- No state machine beyond counters. All registers use nonblocking updates on posedge clk / negedge rst_n.

Decomposition:
- Package arm_pipe_pkg: REG_W, NUM_REGS, reg_idx_t typedef, PC_REG=15 constant (shared with hazard and forwarding logic).
- Sub-module sb_counter: CNT_W-bit up/down counter with inc, dec, clr inputs and zero/full flags. It is instantiated NUM_REGS times via generate.
- Top handles decode of issue_dest/wb_dest to one-hot inc/dec, the outstanding total, and the hazard mux.

Test Plan:
- Reset mid-operation: issue R3 twice, assert rst_n=0 between edges -> busy_vec=0, outstanding=0, issue_ready=1 immediately, no clock needed.
- Basic hazard: issue R5, then src1=5 -> hazard=1. Retire R5, next cycle -> hazard=0. src2=5 with two_src=0 while pending -> hazard=0.
- Saturation: issue R2 three times (CNT_W=2) -> issue_ready=0 for dest 2, count stays 3. Issue R4 same state -> accepted. Retire R2 -> issue_ready=1 next cycle.
- Simultaneous: count[7]=1, issue R7 and retire R7 same cycle -> count[7]=1, outstanding unchanged, hazard on src1=7 stays 1 throughout.
- Underflow: retire R9 with count 0 -> underflow_err=1, count[9]=0, outstanding unchanged. It stays set until flush or reset.
- Flush priority: counts R1=2, R6=1, flush with concurrent issue R1 and retire R6 -> next cycle all counts 0, outstanding=0, underflow_err=0.
